pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 23 ++
 rtl/pc_ras.sv | 60 ++++++
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared encodings and parameter checks for the PC sequencer
package pc_sequencer_pkg;

  // next-PC source select
  localparam logic [2:0] SEL_SEQ    = 3'b000;
  localparam logic [2:0] SEL_BRANCH = 3'b001;
  localparam logic [2:0] SEL_JUMP   = 3'b010;
  localparam logic [2:0] SEL_JREG   = 3'b011;
  localparam logic [2:0] SEL_CALL   = 3'b100;
  localparam logic [2:0] SEL_RET    = 3'b101;

  // branch condition mode
  localparam logic [1:0] BM_BEQ   = 2'b00;
  localparam logic [1:0] BM_BNE   = 2'b01;
  localparam logic [1:0] BM_BEQZ  = 2'b10;
  localparam logic [1:0] BM_NEVER = 2'b11;

  // RAS depth must be a power of two in 2..16 so the pointer wraps naturally
  function automatic bit ras_depth_legal(input int depth);
    return (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with occupancy count
module pc_ras
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  generate
    if (!ras_depth_legal(RAS_DEPTH)) begin : g_bad_depth
      $error("pc_ras: RAS_DEPTH must be a power of two in 2..16");
    end
  endgenerate

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;      // next free slot; top entry sits just below it
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] top_idx;

  assign top_idx   = ptr - PTR_W'(1);
  assign top       = mem[top_idx];
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(RAS_DEPTH));
  assign overflow  = push & full;
  assign underflow = pop & ~push & empty;

  // pointer and count: a push on a full stack overwrites the oldest slot and keeps count saturated
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - CNT_W'(1);
    end
  end

  // entry storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection, PC register and RAS control
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [2:0]       sel,
  input  logic [1:0]       bmode,
  input  logic             zero,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] regdata,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             taken,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] ras_top;
  logic             is_call;
  logic             is_ret;
  logic             cond_met;
  logic             ras_ovf;
  logic             ras_unf;

  assign pc_seq = pc + WIDTH'(1);

  // branch condition resolution
  always_comb begin
    cond_met = 1'b0;
    case (bmode)
      BM_BEQ:   cond_met = zero;
      BM_BNE:   cond_met = ~zero;
      BM_BEQZ:  cond_met = zero;
      BM_NEVER: cond_met = 1'b0;
      default:  cond_met = 1'b0;
    endcase
  end

  // next-PC mux; illegal select codes fall through to sequential with no RAS activity
  always_comb begin
    pc_next = pc_seq;
    taken   = 1'b0;
    is_call = 1'b0;
    is_ret  = 1'b0;
    case (sel)
      SEL_SEQ: ;
      SEL_BRANCH: begin
        if (cond_met) begin
          pc_next = branch_target;
          taken   = 1'b1;
        end
      end
      SEL_JUMP: begin
        pc_next = jump_target;
        taken   = 1'b1;
      end
      SEL_JREG: begin
        pc_next = regdata;
        taken   = 1'b1;
      end
      SEL_CALL: begin
        pc_next = jump_target;
        taken   = 1'b1;
        is_call = 1'b1;
      end
      SEL_RET: begin
        is_ret = 1'b1;
        if (!ras_empty) begin
          pc_next = ras_top;
          taken   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (is_call & ~stall),
    .pop       (is_ret & ~stall),
    .din       (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_ovf),
    .underflow (ras_unf)
  );

  // PC register: advances only when not stalled
  always_ff @(posedge clk) begin
    if (!rst_n)      pc <= RESET_PC;
    else if (!stall) pc <= pc_next;
  end

  // sticky stack error; strobes are already qualified by stall
  always_ff @(posedge clk) begin
    if (!rst_n)                 ras_err <= 1'b0;
    else if (ras_ovf | ras_unf) ras_err <= 1'b1;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  localparam int W = 8;

  localparam logic [2:0] S_SEQ = 3'b000, S_BR = 3'b001, S_JMP = 3'b010,
                         S_JR = 3'b011, S_CALL = 3'b100, S_RET = 3'b101;
  localparam logic [1:0] B_EQ = 2'b00, B_NE = 2'b01, B_EQZ = 2'b10, B_NV = 2'b11;

  typedef struct {
    string        name;
    logic [W-1:0] pc;
    logic [W-1:0] nxt;
    logic         taken;
    logic         empty;
    logic         full;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stall;
  logic [2:0]   sel;
  logic [1:0]   bmode;
  logic         zero;
  logic [W-1:0] branch_target;
  logic [W-1:0] jump_target;
  logic [W-1:0] regdata;
  logic [W-1:0] pc;
  logic [W-1:0] pc_next;
  logic         taken;
  logic         ras_empty;
  logic         ras_full;
  logic         ras_err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_sequencer #(.WIDTH(W), .RAS_DEPTH(4), .RESET_PC(8'd0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .sel           (sel),
    .bmode         (bmode),
    .zero          (zero),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .regdata       (regdata),
    .pc            (pc),
    .pc_next       (pc_next),
    .taken         (taken),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_err       (ras_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
    end
  endtask

  // monitor: the DUT presents a fresh output set every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "pc",        int'(pc),        int'(e.pc));
      chk(e.name, "pc_next",   int'(pc_next),   int'(e.nxt));
      chk(e.name, "taken",     int'(taken),     int'(e.taken));
      chk(e.name, "ras_empty", int'(ras_empty), int'(e.empty));
      chk(e.name, "ras_full",  int'(ras_full),  int'(e.full));
      chk(e.name, "ras_err",   int'(ras_err),   int'(e.err));
    end
  end

  // drive one cycle of inputs and queue the expected mid-cycle outputs
  task automatic step(input string nm, input logic rst, input logic stl,
                      input logic [2:0] s, input logic [1:0] bm, input logic z,
                      input logic [W-1:0] bt, input logic [W-1:0] jt, input logic [W-1:0] rd,
                      input logic [W-1:0] epc, input logic [W-1:0] enx, input logic et,
                      input logic ee, input logic ef, input logic eerr);
    exp_t e;
    rst_n = rst; stall = stl; sel = s; bmode = bm; zero = z;
    branch_target = bt; jump_target = jt; regdata = rd;
    e.name = nm; e.pc = epc; e.nxt = enx; e.taken = et;
    e.empty = ee; e.full = ef; e.err = eerr;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; sel = S_SEQ; bmode = B_NV; zero = 1'b0;
    branch_target = '0; jump_target = '0; regdata = '0;
    repeat (2) @(posedge clk);
    #1;
    //   name        rst stl sel    bm    z  bt  jt   rd  pc   nxt  tk em fu er
    step("seq0",     1, 0, S_SEQ,  B_NV, 0, 0,  0,   0,  0,   1,   0, 1, 0, 0);
    step("seq1",     1, 0, S_SEQ,  B_NV, 0, 0,  0,   0,  1,   2,   0, 1, 0, 0);
    step("seq2",     1, 0, S_SEQ,  B_NV, 0, 0,  0,   0,  2,   3,   0, 1, 0, 0);
    step("jmp10",    1, 0, S_JMP,  B_NV, 0, 0,  10,  0,  3,   10,  1, 1, 0, 0);
    step("beq_t",    1, 0, S_BR,   B_EQ, 1, 40, 0,   0,  10,  40,  1, 1, 0, 0);
    step("bne_nt",   1, 0, S_BR,   B_NE, 1, 77, 0,   0,  40,  41,  0, 1, 0, 0);
    step("beqz_nt",  1, 0, S_BR,   B_EQZ,0, 77, 0,   0,  41,  42,  0, 1, 0, 0);
    step("never",    1, 0, S_BR,   B_NV, 1, 77, 0,   0,  42,  43,  0, 1, 0, 0);
    step("jreg5",    1, 0, S_JR,   B_NV, 0, 0,  0,   5,  43,  5,   1, 1, 0, 0);
    step("call100",  1, 0, S_CALL, B_NV, 0, 0,  100, 0,  5,   100, 1, 1, 0, 0);
    step("ret6",     1, 0, S_RET,  B_NV, 0, 0,  0,   0,  100, 6,   1, 0, 0, 0);
    step("seq6",     1, 0, S_SEQ,  B_NV, 0, 0,  0,   0,  6,   7,   0, 1, 0, 0);
    step("jmp0",     1, 0, S_JMP,  B_NV, 0, 0,  0,   0,  7,   0,   1, 1, 0, 0);
    step("call_a",   1, 0, S_CALL, B_NV, 0, 0,  10,  0,  0,   10,  1, 1, 0, 0);
    step("call_b",   1, 0, S_CALL, B_NV, 0, 0,  20,  0,  10,  20,  1, 0, 0, 0);
    step("call_c",   1, 0, S_CALL, B_NV, 0, 0,  30,  0,  20,  30,  1, 0, 0, 0);
    step("call_d",   1, 0, S_CALL, B_NV, 0, 0,  40,  0,  30,  40,  1, 0, 0, 0);
    step("call_ovf", 1, 0, S_CALL, B_NV, 0, 0,  50,  0,  40,  50,  1, 0, 1, 0);
    step("ret41",    1, 0, S_RET,  B_NV, 0, 0,  0,   0,  50,  41,  1, 0, 1, 1);
    step("ret31",    1, 0, S_RET,  B_NV, 0, 0,  0,   0,  41,  31,  1, 0, 0, 1);
    step("ret21",    1, 0, S_RET,  B_NV, 0, 0,  0,   0,  31,  21,  1, 0, 0, 1);
    step("ret11",    1, 0, S_RET,  B_NV, 0, 0,  0,   0,  21,  11,  1, 0, 0, 1);
    step("ret_unf",  1, 0, S_RET,  B_NV, 0, 0,  0,   0,  11,  12,  0, 1, 0, 1);
    step("seq12",    1, 0, S_SEQ,  B_NV, 0, 0,  0,   0,  12,  13,  0, 1, 0, 1);
    step("stl_c1",   1, 1, S_CALL, B_NV, 0, 0,  200, 0,  13,  200, 1, 1, 0, 1);
    step("stl_c2",   1, 1, S_CALL, B_NV, 0, 0,  200, 0,  13,  200, 1, 1, 0, 1);
    step("call200",  1, 0, S_CALL, B_NV, 0, 0,  200, 0,  13,  200, 1, 1, 0, 1);
    step("ret14",    1, 0, S_RET,  B_NV, 0, 0,  0,   0,  200, 14,  1, 0, 0, 1);
    step("jmp255",   1, 0, S_JMP,  B_NV, 0, 0,  255, 0,  14,  255, 1, 1, 0, 1);
    step("wrap",     1, 0, S_SEQ,  B_NV, 0, 0,  0,   0,  255, 0,   0, 1, 0, 1);
    step("ill111",   1, 0, 3'b111, B_NV, 1, 90, 90,  90, 0,   1,   0, 1, 0, 1);
    step("ill110",   1, 0, 3'b110, B_EQ, 1, 90, 90,  90, 1,   2,   0, 1, 0, 1);
    step("rst_call", 0, 0, S_CALL, B_NV, 0, 0,  77,  0,  2,   77,  1, 1, 0, 1);
    step("stl_ret",  1, 1, S_RET,  B_NV, 0, 0,  0,   0,  0,   1,   0, 1, 0, 0);
    step("ret_unf2", 1, 0, S_RET,  B_NV, 0, 0,  0,   0,  0,   1,   0, 1, 0, 0);
    step("post_unf", 1, 0, S_SEQ,  B_NV, 0, 0,  0,   0,  1,   2,   0, 1, 0, 1);
    @(negedge clk);
    #1;
    chk("drain", "pending", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
